debug_display_scheduler: RTL and testbench
==========================================

# debug_display_scheduler

Sequences the board's four-digit seven-segment debug display for the pipelined MIPS processor. It owns a shared debug read port into the register file, fetches the register chosen by the `test` selector once per display frame, and time-multiplexes the latched value across the four digits. It sits between the processor core's debug read port and the board's `a`–`g` and `A[3:0]` pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `TIMEOUT`, default 255: maximum cycles to wait for `rd_ack` before abandoning a fetch; must be ≥ 1.

- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `test`  in  5  register index to display.
- `half`  in  1  selects the displayed half of the word: 0 = bits [15:0], 1 = bits [31:16].
- `rd_req`  out  1  debug read request to the register file.
- `rd_addr`  out  5  register index for the request; stable while `rd_req` is high.
- `rd_ack`  in  1  read complete; `rd_data` is valid in the same cycle.
- `rd_data`  in  32  read data.
- `seg`  out  7  segment drives, active-low, ordered {a,b,c,d,e,f,g} from bit 6 down to bit 0.
- `A`  out  4  digit anodes, active-low; `A[0]` is the rightmost digit.
- `frame_done`  out  1  one-cycle pulse when a new value is latched.
- `err`  out  1  high after a fetch times out; cleared by the next successful fetch.

## Operation
- **Scan counter.**
  - `cnt` runs 0..REFRESH_DIV-1 continuously.
  - When `cnt` wraps, `digit` (2 bits) increments mod 4.
  - The frame-start event is `cnt==REFRESH_DIV-1 && digit==3`.
- **Fetch FSM** has two states, IDLE and REQ.
  - IDLE→REQ on a frame-start event. At entry, `test` latches into `rd_addr` and `half` latches into `half_q`.
  - The first cycle after reset is release is treated as a frame start, so a fetch begins immediately.
  - REQ: `rd_req`=1. If `rd_ack`=1: latch the selected half of `rd_data` into `disp_val` (16 bits), clear `err`, pulse `frame_done`, and go to IDLE.
  - REQ: if the wait counter reaches TIMEOUT without an ack: set `err`, leave `disp_val` unchanged, and go to IDLE.
- **Ignored events.**
  - A frame start while in REQ is ignored; there is no queuing.
  - `rd_ack` is ignored while in IDLE.
  - Changes to `test` or `half` during REQ do not affect `rd_addr`; they take effect at the next fetch.
- **Display.**
  - `A` = ~(4'b0001 << `digit`).
  - `seg` shows the standard hex glyph of `disp_val[4*digit+3 : 4*digit]`: 0→7'b0000001, 1→7'b1001111, 8→7'b0000000, F→7'b0111000, and so on.
  - While `err`=1, every digit shows a dash (`seg`=7'b1111110).
- **Reset values** (asynchronous, on `reset`=0):
  - `rd_req`=0, `rd_addr`=0, `seg`=7'h7F (all segments off), `A`=4'hF, `frame_done`=0, `err`=0.
  - Internal state: `cnt`=0, `digit`=0, `disp_val`=0, FSM=IDLE.
- **Reset during REQ:** `rd_req` drops asynchronously and no value is latched.

## Timing
- `seg` and `A` are registered one cycle after `digit`/`disp_val` change; there are no combinational paths from inputs to outputs.
- `rd_req` rises on the clock edge after the frame start. It is held until and including the cycle `rd_ack` is sampled high, then falls on the next edge.
- Fastest fetch: an ack arriving in the first REQ cycle gives `frame_done` 2 cycles after the frame start. A newly latched value appears on `seg` 1 cycle after `frame_done`.
- Timeout: `rd_req` is high for exactly TIMEOUT cycles, then `err` rises on the same edge that `rd_req` falls.
- Frame period is 4·REFRESH_DIV cycles. Each anode is low for exactly REFRESH_DIV consecutive cycles, and exactly one anode is low at any time after the first post-reset edge.
- `frame_done` and `err` rising never occur in the same cycle.

## Test plan
(REFRESH_DIV=4, TIMEOUT=8)
1. **Reset.** Hold reset low and drive random inputs → `seg`=7'h7F, `A`=4'hF, `rd_req`=0. Release → `rd_req`=1 with `rd_addr`=`test` on the next edge.
2. **Basic fetch.** `test`=5'd16, `half`=0, ack after 3 cycles with `rd_data`=32'h1234ABCD → one `frame_done` pulse. Digits 0..3 then show D, C, B, A (`seg` 7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000), each for 4 cycles with `A` stepping E→D→B→7.
3. **Upper half and retarget.** `half`=1, and change `test` from 8 to 9 mid-REQ → `rd_addr` stays 8 until the ack. The display shows 1234, and the next frame requests address 9.
4. **Timeout.** Never assert `rd_ack` → `rd_req` is high for 8 cycles, then `err`=1 and all digits show 7'b1111110. The next fetch acked with 32'h0000FFFF → `err`=0 and the display shows FFFF.
5. **Ignored acks and frame starts.** Pulse `rd_ack` during IDLE → no `frame_done`, `disp_val` unchanged. Stall the ack across a frame start → no second request is issued.
6. **Reset during REQ.** Assert `reset` while `rd_req`=1 → `rd_req`=0 immediately with no clock edge, `disp_val`=0, `seg`=7'h7F.

Source files
------------

// File: rtl/debug_display_scheduler.sv
// Four-digit seven-segment debug display sequencer: fetches one register per frame
// over a shared debug read port and scans the latched 16-bit value across the digits.
module debug_display_scheduler #(
    parameter int REFRESH_DIV = 50000,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  test,
    input  logic        half,
    output logic        rd_req,
    output logic [4:0]  rd_addr,
    input  logic        rd_ack,
    input  logic [31:0] rd_data,
    output logic [6:0]  seg,
    output logic [3:0]  A,
    output logic        frame_done,
    output logic        err
);

    localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_p0;
    logic [1:0]         digit_p0;
    logic               first_p0;
    logic               frame_start;
    logic [WAIT_W-1:0]  wcnt;
    logic               half_q;
    logic [15:0]        disp_val;
    logic               load, ack_hit, to_hit;
    logic [3:0]         nib;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Stage p0: scan counter; first_p0 makes the first post-reset cycle a frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0   <= '0;
            digit_p0 <= 2'd0;
            first_p0 <= 1'b1;
        end else begin
            first_p0 <= 1'b0;
            if (cnt_p0 == CNT_LAST) begin
                cnt_p0   <= '0;
                digit_p0 <= digit_p0 + 2'd1;
            end else begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    assign frame_start = first_p0 | ((cnt_p0 == CNT_LAST) && (digit_p0 == 2'd3));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ack_hit   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = IDLE;
                end else if (wcnt == WAIT_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_addr    <= 5'd0;
            half_q     <= 1'b0;
            wcnt       <= '0;
            disp_val   <= 16'd0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= ack_hit;
            if (load) begin
                rd_addr <= test;
                half_q  <= half;
                wcnt    <= '0;
            end else if (state == REQ) begin
                wcnt <= wcnt + 1'b1;
            end
            if (ack_hit) begin
                disp_val <= half_q ? rd_data[31:16] : rd_data[15:0];
                err      <= 1'b0;
            end else if (to_hit) begin
                err <= 1'b1;
            end
        end
    end

    // Decoded from the state register so an asynchronous reset drops it at once
    assign rd_req = (state == REQ);

    assign nib = disp_val[4*digit_p0 +: 4];

    // Stage p1: registered segment and anode drives
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF;
            A   <= 4'hF;
        end else begin
            A   <= ~(4'b0001 << digit_p0);
            seg <= err ? SEG_DASH : hex_glyph(nib);
        end
    end

endmodule

// File: tb/tb_debug_display_scheduler.sv
// Directed bench for debug_display_scheduler with REFRESH_DIV=4, TIMEOUT=8.
module tb_debug_display_scheduler;

    logic        clk;
    logic        reset;
    logic [4:0]  test;
    logic        half;
    logic        rd_req;
    logic [4:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [6:0]  seg;
    logic [3:0]  A;
    logic        frame_done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;
    int ec    = 0;

    logic [6:0] glyph [16];
    logic [3:0] anode [4];

    debug_display_scheduler #(.REFRESH_DIV(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .test(test), .half(half),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .seg(seg), .A(A), .frame_done(frame_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @ec=%0d: got %h, want %h", tag, ec, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ec++;
    endtask

    // Digit lit after edge ec is the one the scan counter held after edge ec-1
    task automatic chk_disp(input logic [15:0] v, input bit dash);
        int d;
        logic [3:0] n;
        d = ((ec - 1) / 4) % 4;
        n = v[4*d +: 4];
        check("anode", {28'd0, A}, {28'd0, anode[d]});
        check("seg", {25'd0, seg}, {25'd0, dash ? 7'b1111110 : glyph[n]});
    endtask

    initial begin
        glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        anode = '{4'hE, 4'hD, 4'hB, 4'h7};

        reset = 1'b0; test = 5'd0; half = 1'b0; rd_ack = 1'b0; rd_data = 32'd0;

        // 1. reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            test = 5'($urandom); half = 1'($urandom);
            rd_ack = 1'($urandom); rd_data = $urandom;
            #2;
            check("rst_seg", {25'd0, seg}, 32'h7F);
            check("rst_A", {28'd0, A}, 32'hF);
            check("rst_req", {31'd0, rd_req}, 32'd0);
            check("rst_fd", {31'd0, frame_done}, 32'd0);
        end
        test = 5'd16; half = 1'b0; rd_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ec = 0;

        // 2. basic fetch, ack after 3 request cycles
        tick();
        check("req_rise", {31'd0, rd_req}, 32'd1);
        check("addr16", {27'd0, rd_addr}, 32'd16);
        chk_disp(16'h0000, 1'b0);
        tick();
        tick();
        check("req_hold", {31'd0, rd_req}, 32'd1);
        rd_ack = 1'b1; rd_data = 32'h1234ABCD;
        tick();
        check("fd_pulse", {31'd0, frame_done}, 32'd1);
        check("req_fall", {31'd0, rd_req}, 32'd0);
        rd_ack = 1'b0; rd_data = 32'hDEADBEEF;
        tick();
        check("fd_low", {31'd0, frame_done}, 32'd0);
        chk_disp(16'hABCD, 1'b0);
        while (ec < 15) begin
            tick();
            chk_disp(16'hABCD, 1'b0);
        end

        // 3. upper half, retarget mid-request
        half = 1'b1; test = 5'd8;
        tick();
        check("req2", {31'd0, rd_req}, 32'd1);
        check("addr8", {27'd0, rd_addr}, 32'd8);
        chk_disp(16'hABCD, 1'b0);
        tick();
        chk_disp(16'hABCD, 1'b0);
        test = 5'd9; half = 1'b0;
        tick();
        check("addr8_hold", {27'd0, rd_addr}, 32'd8);
        chk_disp(16'hABCD, 1'b0);
        rd_ack = 1'b1; rd_data = 32'h1234ABCD;
        tick();
        check("fd_upper", {31'd0, frame_done}, 32'd1);
        chk_disp(16'hABCD, 1'b0);
        rd_ack = 1'b0;
        while (ec < 31) begin
            tick();
            chk_disp(16'h1234, 1'b0);
        end

        // 4. timeout, then recovery
        tick();
        check("addr9", {27'd0, rd_addr}, 32'd9);
        chk_disp(16'h1234, 1'b0);
        while (ec < 40) begin
            check("to_req_hi", {31'd0, rd_req}, 32'd1);
            check("to_err_lo", {31'd0, err}, 32'd0);
            tick();
        end
        check("to_req_fall", {31'd0, rd_req}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_fd", {31'd0, frame_done}, 32'd0);
        chk_disp(16'h1234, 1'b0);
        while (ec < 48) begin
            tick();
            chk_disp(16'h0000, 1'b1);
        end
        check("rec_req", {31'd0, rd_req}, 32'd1);
        rd_ack = 1'b1; rd_data = 32'h0000FFFF;
        tick();
        check("rec_fd", {31'd0, frame_done}, 32'd1);
        check("rec_err", {31'd0, err}, 32'd0);
        chk_disp(16'h0000, 1'b1);
        rd_ack = 1'b0;
        while (ec < 55) begin
            tick();
            chk_disp(16'hFFFF, 1'b0);
        end

        // 5. ack while idle is ignored; timed-out request is not reissued
        rd_ack = 1'b1; rd_data = 32'h00001234;
        tick();
        check("idle_ack_fd", {31'd0, frame_done}, 32'd0);
        rd_ack = 1'b0;
        while (ec < 63) begin
            tick();
            chk_disp(16'hFFFF, 1'b0);
            check("idle_req", {31'd0, rd_req}, 32'd0);
        end
        tick();
        check("req3", {31'd0, rd_req}, 32'd1);
        while (ec < 72) tick();
        check("to2_err", {31'd0, err}, 32'd1);
        while (ec < 79) begin
            check("no_reissue", {31'd0, rd_req}, 32'd0);
            check("no_fd", {31'd0, frame_done}, 32'd0);
            tick();
        end
        tick();
        check("req4", {31'd0, rd_req}, 32'd1);
        tick();

        // 6. asynchronous reset during a request
        check("pre_rst_req", {31'd0, rd_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", {31'd0, rd_req}, 32'd0);
        check("arst_seg", {25'd0, seg}, 32'h7F);
        check("arst_A", {28'd0, A}, 32'hF);
        check("arst_err", {31'd0, err}, 32'd0);
        test = 5'd3;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ec = 0;
        tick();
        check("rel_req", {31'd0, rd_req}, 32'd1);
        check("rel_addr", {27'd0, rd_addr}, 32'd3);
        chk_disp(16'h0000, 1'b0);
        rd_ack = 1'b1; rd_data = 32'h00005678;
        tick();
        check("rel_fd", {31'd0, frame_done}, 32'd1);
        rd_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
